// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle for uart_transmitter: producer handshake plus the TX line.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready,
    input  serial_out
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready,
    output serial_out
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1, 11-bit frame).
module uart_transmitter #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              accept;
  logic              bit_end;

  // Ready is held low combinationally during reset so nothing is accepted then.
  assign tx.data_in_ready = (state_q == IDLE) && !rst;
  assign tx.serial_out    = tx_q;
  assign accept           = tx.data_in_valid && tx.data_in_ready;
  assign bit_end          = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (accept) begin
          state_d  = START;
          shreg_d  = tx.data_in;
          bit_d    = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx.data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        // The shift register always holds the next bit to send in position 0.
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected bytes, a monitor checks each frame.
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 100_000_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int SET        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam int NRAND = 1;
`else
  localparam int NBITS = 10;
  localparam int NRAND = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if bus ();

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (bus)
  );

  int checks   = 0;
  int failures = 0;
  int idle_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] b);
    logic pend;
    int   bad;
    int   rdy_bad;
    pend    = 1'b0;
    rdy_bad = 0;
    for (int i = 0; i < NBITS; i++) begin
      bad = 0;
      for (int c = 0; c < SET; c++) begin
        @(negedge clk);
        if (pend) begin
          check("rst_abort_line", 32'(bus.serial_out), 32'd1);
          return;
        end
        if (bus.serial_out !== frame_bit(b, i)) bad++;
        if (bus.data_in_ready !== 1'b0) rdy_bad++;
        if (rst) pend = 1'b1;
      end
      check($sformatf("frame_%02h_bit%0d_badcycles", b, i), 32'(bad), 32'd0);
    end
    check($sformatf("frame_%02h_ready_low", b), 32'(rdy_bad), 32'd0);
    @(negedge clk);
    check($sformatf("frame_%02h_ready_return", b), 32'(bus.data_in_ready), 32'd1);
    check($sformatf("frame_%02h_idle_gap_line", b), 32'(bus.serial_out), 32'd1);
  endtask

  // Monitor: an acceptance is seen at the negedge before the accepting posedge.
  initial begin
    logic [7:0] e;
    @(negedge clk);
    forever begin
      if (!rst && bus.data_in_valid && bus.data_in_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept: got byte %02h expected no acceptance", bus.data_in);
          e = bus.data_in;
        end else begin
          e = exp_q.pop_front();
        end
        check_frame(e);
      end else begin
        if (!rst && bus.serial_out !== 1'b1) idle_bad++;
        @(negedge clk);
      end
    end
  end

  task automatic wait_accept();
    int n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < NBITS * SET + 50) begin
      @(negedge clk);
      acc = !rst && bus.data_in_valid && bus.data_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_seen", 32'(acc), 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    exp_q.push_back(b);
    bus.data_in       = b;
    bus.data_in_valid = 1'b1;
    wait_accept();
    if (!hold) bus.data_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < NBITS * SET + 50) begin
      @(negedge clk);
      rdy = bus.data_in_ready;
      n++;
    end
    check("idle_reached", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] r;
    rst               = 1'b1;
    bus.data_in       = 8'h11;
    bus.data_in_valid = 1'b1;
    bad               = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.serial_out !== 1'b1 || bus.data_in_ready !== 1'b0) bad++;
    end
    check("reset_hold_line_ready", 32'(bad), 32'd0);
    rst               = 1'b0;
    bus.data_in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.data_in_ready), 32'd1);
    check("line_after_reset", 32'(bus.serial_out), 32'd1);
    @(posedge clk);
    #1;

    send(8'h55, 1'b0);
    wait_idle();

    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    bus.data_in_valid = 1'b0;
    bus.data_in       = 8'($urandom);
    wait_idle();

    send(8'hFF, 1'b0);
    bus.data_in = 8'h00;
    repeat (3 * SET) @(posedge clk);
    #1;
    bus.data_in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    wait_idle();

    send(8'h0F, 1'b0);
    repeat (4 * SET + SET / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.serial_out !== 1'b1 || bus.data_in_ready !== 1'b0) bad++;
    end
    check("midframe_reset_line_ready", 32'(bad), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midframe_reset", 32'(bus.data_in_ready), 32'd1);
    @(posedge clk);
    #1;

    send(8'h81, 1'b0);
    wait_idle();

    for (int i = 0; i < NRAND; i++) begin
      r = 8'($urandom);
      send(r, (i < NRAND - 1));
    end
    bus.data_in_valid = 1'b0;
    wait_idle();

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b0);
    wait_idle();
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_line_high", 32'(idle_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
